// File: rtl/vdc_pkg.sv
// vdc_pkg: shared types and defaults for the VDC video RAM arbiter.
package vdc_pkg;
    typedef enum logic {S_RUN, S_REFRESH} state_e;
    typedef enum logic [1:0] {T_NONE, T_DISP, T_CPU} tag_e;
    localparam logic [3:0] STARVE_LIMIT_DEF = 4'd7;
endpackage

// File: rtl/vdc_refresh_ctr.sv
// vdc_refresh_ctr: per-line DRAM refresh sequencer (state, cycle counter, row counter).
module vdc_refresh_ctr
    import vdc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       line_start_i,
    input  logic [3:0] refresh_cnt_i,
    output logic       start_o,
    output logic       refreshing_o,
    output logic       refresh_next_o,
    output logic [7:0] row_next_o
);
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] row_q, row_d;
    assign start_o = line_start_i && refresh_cnt_i != 4'd0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        if (state_q == S_REFRESH) begin
            row_d = row_q + 8'd1;
            cnt_d = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? S_RUN : S_REFRESH;
        end
        // a new line restarts the count even mid-refresh
        if (start_o) begin
            state_d = S_REFRESH;
            cnt_d   = refresh_cnt_i;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end
    assign refreshing_o   = state_q == S_REFRESH;
    assign refresh_next_o = state_d == S_REFRESH;
    assign row_next_o     = row_d;
endmodule

// File: rtl/vdc_ram_arb.sv
// vdc_ram_arb: display-priority spram arbiter with CPU starvation guard and refresh insertion.
module vdc_ram_arb
    import vdc_pkg::*;
#(
    parameter logic [3:0] STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ramsize,
    input  logic        line_start,
    input  logic [3:0]  refresh_cnt,
    input  logic        disp_req,
    input  logic [15:0] disp_addr,
    output logic        disp_gnt,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_valid,
    output logic [7:0]  cpu_rdata,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_di,
    input  logic [7:0]  ram_do,
    output logic        refreshing
);
    logic        start, refresh_next, run, starved, any_gnt;
    logic [7:0]  row_next;
    logic [3:0]  starve_q, starve_d;
    logic [15:0] req_addr, ram_addr_d;
    logic [7:0]  ram_di_d;
    logic        ram_we_d;
    tag_e        tag1_q, tag1_d, tag2_q;

    vdc_refresh_ctr u_refresh (
        .clk           (clk),
        .reset         (reset),
        .line_start_i  (line_start),
        .refresh_cnt_i (refresh_cnt),
        .start_o       (start),
        .refreshing_o  (refreshing),
        .refresh_next_o(refresh_next),
        .row_next_o    (row_next)
    );

    assign run      = !refreshing && !start;
    assign starved  = cpu_req && starve_q == STARVE_LIMIT;
    assign disp_gnt = run && disp_req && !starved;
    assign cpu_gnt  = run && cpu_req && !disp_gnt;
    assign any_gnt  = disp_gnt || cpu_gnt;

    always_comb begin
        starve_d   = refreshing ? starve_q :
                     (!cpu_req || cpu_gnt) ? 4'd0 :
                     (starve_q == STARVE_LIMIT) ? starve_q : starve_q + 4'd1;
        req_addr   = disp_gnt ? disp_addr : cpu_addr;
        ram_we_d   = cpu_gnt && cpu_we;
        // refresh address lines up with the cycles in which refreshing is high
        ram_addr_d = refresh_next ? {8'h00, row_next} :
                     any_gnt ? (ramsize ? req_addr : {2'b00, req_addr[13:0]}) : ram_addr;
        ram_di_d   = any_gnt ? cpu_wdata : ram_di;
        tag1_d     = disp_gnt ? T_DISP : (cpu_gnt && !cpu_we) ? T_CPU : T_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            tag1_q   <= T_NONE;
            tag2_q   <= T_NONE;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_di   <= '0;
        end else begin
            starve_q <= starve_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag1_q;
            ram_we   <= ram_we_d;
            ram_addr <= ram_addr_d;
            ram_di   <= ram_di_d;
        end
    end

    assign disp_valid = tag2_q == T_DISP;
    assign cpu_valid  = tag2_q == T_CPU;
    assign disp_data  = ram_do;
    assign cpu_rdata  = ram_do;
endmodule
